// File: rtl/core_pkg.sv
// Shared decode definitions: opcodes, ALU operation encoding, immediate formats,
// the decode FSM state type and the ID/EX register layout.
package core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } dec_state_t;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } imm_fmt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    alu_op_t     alu_op;
    logic        src_imm;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        illegal;
  } id_ex_t;

  function automatic imm_fmt_t opc_fmt(input logic [6:0] opc);
    imm_fmt_t fmt;
    fmt = FMT_NONE;
    case (opc)
      OPC_OP:                                fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:        fmt = FMT_I;
      OPC_STORE:                             fmt = FMT_S;
      OPC_BRANCH:                            fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                    fmt = FMT_U;
      OPC_JAL:                               fmt = FMT_J;
      default:                               fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  // bit 30 selects SUB only for register-register ops; for shifts it selects SRA
  function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic b30,
                                             input logic is_reg);
    alu_op_t op;
    op = ALU_ADD;
    case (f3)
      3'd0:    op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; sign-extends I/S/B/U/J formats, zero for
// register-register and unsupported opcodes.
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (opc_fmt(instr_i[6:0]))
      FMT_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      FMT_U:   imm_o = {instr_i[31:12], 12'b0};
      FMT_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage with ID/EX register, load-use bubble insertion and flush.
// Optional macro DECODE_WB_BYPASS_EN forwards the same-cycle writeback into captured operands.
//
// state  | meaning
// RUN    | normal decode; accepts from fetch whenever the ID/EX slot frees up
// BUBBLE | NOP held in ID/EX after a load-use hazard; fetch stays stalled
module decode_stage
  import core_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid_i,
  output logic        if_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        wb_wr_en_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_rs1_data_o,
  output logic [31:0] id_rs2_data_o,
  output logic [31:0] id_imm_o,
  output logic [4:0]  id_rd_addr_o,
  output logic [3:0]  id_alu_op_o,
  output logic        id_src_imm_o,
  output logic        id_mem_rd_o,
  output logic        id_mem_wr_o,
  output logic        id_reg_wr_o,
  output logic        id_illegal_o
);

  dec_state_t  state_q, state_d;
  logic        id_valid_q, id_valid_d;
  id_ex_t      id_ex_q, id_ex_d;

  logic [6:0]  opcode;
  logic [4:0]  rd_field;
  logic [31:0] dec_imm;
  logic [31:0] op1, op2;
  alu_op_t     dec_alu;
  logic        dec_src_imm, dec_mem_rd, dec_mem_wr, dec_writes_rd, dec_illegal;
  logic        use_rs1, use_rs2;
  id_ex_t      dec_entry;
  logic        hazard, in_fire, out_fire;

  assign opcode     = instr_i[6:0];
  assign rd_field   = instr_i[11:7];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  imm_gen u_imm_gen (
    .instr_i (instr_i),
    .imm_o   (dec_imm)
  );

`ifdef DECODE_WB_BYPASS_EN
  logic byp_rs1, byp_rs2;
  assign byp_rs1 = wb_wr_en_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == rs1_addr_o);
  assign byp_rs2 = wb_wr_en_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == rs2_addr_o);
  assign op1     = byp_rs1 ? wb_data_i : rs1_data_i;
  assign op2     = byp_rs2 ? wb_data_i : rs2_data_i;
`else
  logic unused_wb;
  assign op1       = rs1_data_i;
  assign op2       = rs2_data_i;
  assign unused_wb = ^{wb_wr_en_i, wb_rd_addr_i, wb_data_i};
`endif

  always_comb begin
    dec_alu       = ALU_ADD;
    dec_src_imm   = 1'b0;
    dec_mem_rd    = 1'b0;
    dec_mem_wr    = 1'b0;
    dec_writes_rd = 1'b0;
    dec_illegal   = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_alu       = alu_from_funct(instr_i[14:12], instr_i[30], 1'b1);
        dec_writes_rd = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_alu       = alu_from_funct(instr_i[14:12], instr_i[30], 1'b0);
        dec_src_imm   = 1'b1;
        dec_writes_rd = 1'b1;
        use_rs1       = 1'b1;
      end
      OPC_LOAD: begin
        dec_src_imm   = 1'b1;
        dec_mem_rd    = 1'b1;
        dec_writes_rd = 1'b1;
        use_rs1       = 1'b1;
      end
      OPC_STORE: begin
        dec_src_imm = 1'b1;
        dec_mem_wr  = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OPC_BRANCH: begin
        dec_alu = ALU_SUB;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_JALR: begin
        dec_src_imm   = 1'b1;
        dec_writes_rd = 1'b1;
        use_rs1       = 1'b1;
      end
      OPC_JAL, OPC_AUIPC: begin
        dec_src_imm   = 1'b1;
        dec_writes_rd = 1'b1;
      end
      OPC_LUI: begin
        dec_alu       = ALU_PASSB;
        dec_src_imm   = 1'b1;
        dec_writes_rd = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // rd is reported only for formats that write it, so S/B/illegal carry rd = 0
  always_comb begin
    dec_entry          = '0;
    dec_entry.pc       = pc_i;
    dec_entry.rs1_data = op1;
    dec_entry.rs2_data = op2;
    dec_entry.imm      = dec_imm;
    dec_entry.rd_addr  = dec_writes_rd ? rd_field : 5'd0;
    dec_entry.alu_op   = dec_alu;
    dec_entry.src_imm  = dec_src_imm;
    dec_entry.mem_rd   = dec_mem_rd;
    dec_entry.mem_wr   = dec_mem_wr;
    dec_entry.reg_wr   = dec_writes_rd && (rd_field != 5'd0);
    dec_entry.illegal  = dec_illegal;
  end

  assign hazard = (LOAD_USE_STALL != 0) && if_valid_i && id_valid_q && id_ex_q.mem_rd &&
                  (id_ex_q.rd_addr != 5'd0) &&
                  ((use_rs1 && (rs1_addr_o == id_ex_q.rd_addr)) ||
                   (use_rs2 && (rs2_addr_o == id_ex_q.rd_addr)));

  assign if_ready_o = (!id_valid_q || ex_ready_i) && (state_q == ST_RUN) && !hazard;
  assign in_fire    = if_valid_i && if_ready_o && !flush_i;
  assign out_fire   = id_valid_q && ex_ready_i;

  always_comb begin
    state_d    = state_q;
    id_valid_d = id_valid_q;
    id_ex_d    = id_ex_q;
    if (flush_i) begin
      id_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (in_fire) begin
            id_ex_d    = dec_entry;
            id_valid_d = 1'b1;
          end else if (hazard && out_fire) begin
            // the load leaves this cycle; a NOP takes its place
            id_ex_d    = '0;
            id_valid_d = 1'b1;
            state_d    = ST_BUBBLE;
          end else if (out_fire) begin
            id_valid_d = 1'b0;
          end
        end
        ST_BUBBLE: begin
          if (ex_ready_i) begin
            id_valid_d = 1'b0;
            state_d    = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      id_valid_q <= 1'b0;
      id_ex_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      id_ex_q    <= id_ex_d;
    end
  end

  assign id_valid_o    = id_valid_q;
  assign id_pc_o       = id_ex_q.pc;
  assign id_rs1_data_o = id_ex_q.rs1_data;
  assign id_rs2_data_o = id_ex_q.rs2_data;
  assign id_imm_o      = id_ex_q.imm;
  assign id_rd_addr_o  = id_ex_q.rd_addr;
  assign id_alu_op_o   = id_ex_q.alu_op;
  assign id_src_imm_o  = id_ex_q.src_imm;
  assign id_mem_rd_o   = id_ex_q.mem_rd;
  assign id_mem_wr_o   = id_ex_q.mem_wr;
  assign id_reg_wr_o   = id_ex_q.reg_wr;
  assign id_illegal_o  = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions with hand-decoded expectations.
module tb_decode_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid_i, if_ready_o;
  logic [31:0] instr_i, pc_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        wb_wr_en_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        id_valid_o, ex_ready_i;
  logic [31:0] id_pc_o, id_rs1_data_o, id_rs2_data_o, id_imm_o;
  logic [4:0]  id_rd_addr_o;
  logic [3:0]  id_alu_op_o;
  logic        id_src_imm_o, id_mem_rd_o, id_mem_wr_o, id_reg_wr_o, id_illegal_o;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_valid_i    (if_valid_i),
    .if_ready_o    (if_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .wb_wr_en_i    (wb_wr_en_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_data_i     (wb_data_i),
    .flush_i       (flush_i),
    .id_valid_o    (id_valid_o),
    .ex_ready_i    (ex_ready_i),
    .id_pc_o       (id_pc_o),
    .id_rs1_data_o (id_rs1_data_o),
    .id_rs2_data_o (id_rs2_data_o),
    .id_imm_o      (id_imm_o),
    .id_rd_addr_o  (id_rd_addr_o),
    .id_alu_op_o   (id_alu_op_o),
    .id_src_imm_o  (id_src_imm_o),
    .id_mem_rd_o   (id_mem_rd_o),
    .id_mem_wr_o   (id_mem_wr_o),
    .id_reg_wr_o   (id_reg_wr_o),
    .id_illegal_o  (id_illegal_o)
  );

  int     checks = 0;
  int     errors = 0;
  id_ex_t exp_q[$];
  int     tag_q[$];
  id_ex_t mon_e;
  int     mon_t;

  function automatic id_ex_t mk(input logic [31:0] pc, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] imm,
                                input logic [4:0] rd, input alu_op_t op, input logic si,
                                input logic mr, input logic mw, input logic rw,
                                input logic il);
    id_ex_t e;
    e = '{pc: pc, rs1_data: r1, rs2_data: r2, imm: imm, rd_addr: rd, alu_op: op,
          src_imm: si, mem_rd: mr, mem_wr: mw, reg_wr: rw, illegal: il};
    return e;
  endfunction

  function automatic id_ex_t cur_out();
    return mk(id_pc_o, id_rs1_data_o, id_rs2_data_o, id_imm_o, id_rd_addr_o,
              alu_op_t'(id_alu_op_o), id_src_imm_o, id_mem_rd_o, id_mem_wr_o,
              id_reg_wr_o, id_illegal_o);
  endfunction

  task automatic chk_out(input string name, input id_ex_t act, input id_ex_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush_i && id_valid_o && ex_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected actual_pc=%h required=no_output", id_pc_o);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        chk_out($sformatf("out_tag%0d", mon_t), cur_out(), mon_e);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d1,
                      input logic [31:0] d2, input bit push, input id_ex_t e, input int tag);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    if_valid_i = 1'b1;
    instr_i    = ins;
    pc_i       = pc;
    rs1_data_i = d1;
    rs2_data_i = d2;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (if_ready_o) begin
        if (push) begin
          exp_q.push_back(e);
          tag_q.push_back(tag);
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%0d actual=not_accepted required=accepted", tag);
    end
    @(posedge clk);
    #1;
    if_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] byp_exp;
    id_ex_t      lui_e;
    rst_n = 1'b0; if_valid_i = 1'b0; instr_i = '0; pc_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; wb_wr_en_i = 1'b0; wb_rd_addr_i = '0;
    wb_data_i = '0; flush_i = 1'b0; ex_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_int("rst_valid", int'(id_valid_o), 0);
    chk_out("rst_outputs", cur_out(), '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk_int("rel_ready", int'(if_ready_o), 1);
    chk_int("rel_valid", int'(id_valid_o), 0);

    // ADDI x1,x0,5
    send(32'h00500093, 32'h100, 32'h0, 32'h0, 1'b1,
         mk(32'h100, 0, 0, 32'd5, 5'd1, ALU_ADD, 1, 0, 0, 1, 0), 1);
    @(negedge clk);
    chk_int("addi_valid_next", int'(id_valid_o), 1);

    // LW x2,0(x1) then ADD x3,x2,x2 -> NOP bubble between them
    send(32'h0000A103, 32'h104, 32'h40, 32'h11, 1'b1,
         mk(32'h104, 32'h40, 32'h11, 32'h0, 5'd2, ALU_ADD, 1, 1, 0, 1, 0), 2);
    exp_q.push_back('0);
    tag_q.push_back(3);
    if_valid_i = 1'b1; instr_i = 32'h002101B3; pc_i = 32'h108;
    rs1_data_i = 32'd7; rs2_data_i = 32'd7;
    @(negedge clk);
    chk_int("hazard_ready", int'(if_ready_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_int("bubble_ready", int'(if_ready_o), 0);
    chk_int("bubble_valid", int'(id_valid_o), 1);
    send(32'h002101B3, 32'h108, 32'd7, 32'd7, 1'b1,
         mk(32'h108, 32'd7, 32'd7, 32'h0, 5'd3, ALU_ADD, 0, 0, 0, 1, 0), 4);

    // SW x5,-4(x2); BEQ x1,x2,16; JAL x1,-8
    send(32'hFE512E23, 32'h10C, 32'h200, 32'h55, 1'b1,
         mk(32'h10C, 32'h200, 32'h55, 32'hFFFFFFFC, 5'd0, ALU_ADD, 1, 0, 1, 0, 0), 5);
    send(32'h00208863, 32'h110, 32'd3, 32'd3, 1'b1,
         mk(32'h110, 32'd3, 32'd3, 32'd16, 5'd0, ALU_SUB, 0, 0, 0, 0, 0), 6);
    send(32'hFF9FF0EF, 32'h114, 32'h0, 32'h0, 1'b1,
         mk(32'h114, 0, 0, 32'hFFFFFFF8, 5'd1, ALU_ADD, 1, 0, 0, 1, 0), 7);

    // unsupported opcode, then ADDI x0,x0,1
    send(32'h0000007F, 32'h118, 32'h0, 32'h0, 1'b1,
         mk(32'h118, 0, 0, 32'h0, 5'd0, ALU_ADD, 0, 0, 0, 0, 1), 8);
    send(32'h00100013, 32'h11C, 32'h0, 32'h0, 1'b1,
         mk(32'h11C, 0, 0, 32'd1, 5'd0, ALU_ADD, 1, 0, 0, 0, 0), 9);

    // ADD x6,x5,x0 while writeback drives x5
`ifdef DECODE_WB_BYPASS_EN
    byp_exp = 32'hDEADBEEF;
`else
    byp_exp = 32'h0;
`endif
    wb_wr_en_i = 1'b1; wb_rd_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    send(32'h00028333, 32'h120, 32'h0, 32'h0, 1'b1,
         mk(32'h120, byp_exp, 32'h0, 32'h0, 5'd6, ALU_ADD, 0, 0, 0, 1, 0), 10);
    wb_wr_en_i = 1'b0; wb_rd_addr_i = '0; wb_data_i = '0;
    @(negedge clk);
    chk_int("rs1_addr", int'(rs1_addr_o), 5);
    chk_int("rs2_addr", int'(rs2_addr_o), 0);
    @(posedge clk); #1;

    // LUI x4,0x12345 held for 3 cycles with ex_ready low
    ex_ready_i = 1'b0;
    lui_e = mk(32'h124, 0, 0, 32'h12345000, 5'd4, ALU_PASSB, 1, 0, 0, 1, 0);
    send(32'h12345237, 32'h124, 32'h0, 32'h0, 1'b1, lui_e, 11);
    instr_i = 32'hFFFFFFFF; pc_i = 32'hAAAA5555; rs1_data_i = 32'h1234; rs2_data_i = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_int($sformatf("stall_ready%0d", i), int'(if_ready_o), 0);
      chk_out($sformatf("stall_hold%0d", i), cur_out(), lui_e);
      @(posedge clk); #1;
    end
    ex_ready_i = 1'b1;
    @(posedge clk); #1;

    // flush kills the held ADDI x7 and the ADDI offered in the same cycle
    ex_ready_i = 1'b0;
    send(32'h00900393, 32'h128, 32'h0, 32'h0, 1'b0, '0, 0);
    if_valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h12C; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; if_valid_i = 1'b0; ex_ready_i = 1'b1;
    @(negedge clk);
    chk_int("flush_valid", int'(id_valid_o), 0);
    send(32'h00500093, 32'h130, 32'h0, 32'h0, 1'b1,
         mk(32'h130, 0, 0, 32'd5, 5'd1, ALU_ADD, 1, 0, 0, 1, 0), 12);
    @(negedge clk);
    @(posedge clk); #1;

    // reset while an instruction sits in ID/EX
    send(32'h00700213, 32'h134, 32'h0, 32'h0, 1'b0, '0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_int("midrst_valid", int'(id_valid_o), 0);
    chk_out("midrst_outputs", cur_out(), '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk_int("postrst_ready", int'(if_ready_o), 1);
    chk_int("postrst_valid", int'(id_valid_o), 0);

    repeat (2) @(posedge clk);
    chk_int("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
